// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: default width, slice sizing and reference
// conversions used by the decoder pipeline and its bench.
package gray_pkg;

    localparam int WIDTH_DEF = 10;

    function automatic int slice_size(input int w, input int p);
        return (w + p - 1) / p;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g,
                                             input int w);
        logic [31:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_slice.sv
// Combinational Gray-to-binary decode of one MSB-first slice,
// seeded by the already-decoded binary bit just above the slice.
module gray2bin_slice #(
    parameter int N = 5
) (
    input  logic         carry_in,
    input  logic [N-1:0] g,
    output logic [N-1:0] b
);

    always_comb begin
        logic acc;
        acc = carry_in;
        b   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
    end

endmodule

// File: rtl/dec_gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder with per-stage valid/ready flow control.
// Define DEC_GRAY2BIN_SEQ_CHECK_EN to flag words breaking the Gray step rule.
module dec_gray2bin_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             seq_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int P = PIPE_STAGES;
    localparam int S = slice_size(WIDTH, PIPE_STAGES);

    logic [WIDTH-1:0] stage_in  [P];
    logic [WIDTH-1:0] stage_out [P];
    logic [WIDTH-1:0] data_q    [P];
    logic [WIDTH-1:0] data_d    [P];
    logic [P-1:0]     v_q, v_d, err_q, err_d;
    logic [P-1:0]     adv, load, up_v, up_err;
    logic             in_err;

    for (genvar k = 0; k < P; k++) begin : g_stage
        localparam int HI = WIDTH - 1 - k * S;
        localparam int LO = (HI - S + 1 < 0) ? 0 : HI - S + 1;

        if (k == 0) begin : g_first
            assign stage_in[k] = gray;
        end else begin : g_next
            assign stage_in[k] = data_q[k-1];
        end

        if (HI < 0) begin : g_empty
            assign stage_out[k] = stage_in[k];
        end else begin : g_slice
            logic             carry;
            logic [HI-LO:0]   b;
            logic [WIDTH-1:0] so;

            if (HI == WIDTH - 1) begin : g_top
                assign carry = 1'b0;
            end else begin : g_mid
                assign carry = stage_in[k][HI+1];
            end

            gray2bin_slice #(.N(HI - LO + 1)) u_slice (
                .carry_in (carry),
                .g        (stage_in[k][HI:LO]),
                .b        (b)
            );

            always_comb begin
                so        = stage_in[k];
                so[HI:LO] = b;
            end

            assign stage_out[k] = so;
        end
    end

    // Ready ripples back from the consumer so bubbles collapse.
    always_comb begin
        logic       ok;
        logic [P:0] vv;
        logic [P:0] ee;
        adv    = '0;
        load   = '0;
        ok     = out_ready;
        for (int k = P - 1; k >= 0; k--) begin
            adv[k]  = v_q[k] & ok;
            load[k] = ~v_q[k] | adv[k];
            ok      = load[k];
        end
        vv     = {v_q, in_valid};
        ee     = {err_q, in_err};
        up_v   = vv[P-1:0];
        up_err = ee[P-1:0];
        for (int k = 0; k < P; k++) begin
            v_d[k]    = load[k] ? up_v[k] : v_q[k];
            err_d[k]  = (load[k] & up_v[k]) ? up_err[k] : err_q[k];
            data_d[k] = (load[k] & up_v[k]) ? stage_out[k] : data_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            err_q <= '0;
            for (int k = 0; k < P; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[P-1];
    assign bin       = data_q[P-1];
    assign seq_err   = err_q[P-1];

`ifdef DEC_GRAY2BIN_SEQ_CHECK_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_in;

    always_comb begin
        acc_in = in_valid & in_ready;
        in_err = acc_in & seen_q & ($countones(gray ^ prev_q) > 1);
        prev_d = acc_in ? gray : prev_q;
        seen_d = seen_q | acc_in;
        cnt_d  = cnt_q;
        if (out_valid & out_ready & err_q[P-1] & (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign in_err  = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dec_gray2bin_pipe.sv
// Bench for dec_gray2bin_pipe at PIPE_STAGES 2, 1 and 4 sharing one stimulus.
// Each instance is tracked by a queue model of accepted words.
module tb_dec_gray2bin_pipe;
    import gray_pkg::*;

    localparam int W  = 10;
    localparam int ND = 3;
`ifdef DEC_GRAY2BIN_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] gray;

    logic         in_ready_w  [ND];
    logic [W-1:0] bin_w       [ND];
    logic         out_valid_w [ND];
    logic         seq_err_w   [ND];
    logic [7:0]   err_cnt_w   [ND];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic int ps(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dec_gray2bin_pipe #(
            .WIDTH       (W),
            .PIPE_STAGES ((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
            .CNT_W       (8)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .gray      (gray),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .bin       (bin_w[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .seq_err   (seq_err_w[g]),
            .err_cnt   (err_cnt_w[g])
        );
    end

    // Binary bit i is the parity of all Gray bits at or above i.
    function automatic logic [W-1:0] model_dec(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic int hamming(input logic [W-1:0] a,
                                   input logic [W-1:0] c);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (a[i] != c[i]) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [W:0] exp_q [ND][$];
    logic [W:0] got0 [$];
    int         cnt_m  [ND];
    logic       seen_m [ND];
    logic [W-1:0] prev_m [ND];
    logic       stall_m [ND];
    logic [W:0] held_m [ND];

    always @(negedge clk) begin
        logic [W:0] e;
        logic       e_err;
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                exp_q[k].delete();
                cnt_m[k]   = 0;
                seen_m[k]  = 1'b0;
                stall_m[k] = 1'b0;
            end else begin
                check($sformatf("in_ready[%0d]", k), in_ready_w[k],
                      (exp_q[k].size() < ps(k)) || out_ready);
                check($sformatf("err_cnt[%0d]", k), err_cnt_w[k], cnt_m[k]);
                check($sformatf("out_without_word[%0d]", k),
                      out_valid_w[k] && exp_q[k].size() == 0, 0);
                if (stall_m[k])
                    check($sformatf("hold[%0d]", k),
                          {out_valid_w[k], seq_err_w[k], bin_w[k]},
                          {1'b1, held_m[k]});
                if (out_valid_w[k] && out_ready && exp_q[k].size() > 0) begin
                    e = exp_q[k].pop_front();
                    check($sformatf("word[%0d]", k),
                          {seq_err_w[k], bin_w[k]}, e);
                    if (k == 0) got0.push_back({seq_err_w[k], bin_w[k]});
                    if (e[W] && cnt_m[k] < 255) cnt_m[k]++;
                end
                if (in_valid && in_ready_w[k]) begin
                    e_err = CHK && seen_m[k] && (hamming(gray, prev_m[k]) > 1);
                    exp_q[k].push_back({e_err, model_dec(gray)});
                    prev_m[k] = gray;
                    seen_m[k] = 1'b1;
                end
                stall_m[k] = out_valid_w[k] && !out_ready;
                held_m[k]  = {seq_err_w[k], bin_w[k]};
            end
        end
    end

    task automatic send(input logic [W-1:0] g);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        gray     = g;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready_w[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_accept", in_ready_w[0], 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int   lat [ND];
        int   n;
        int   idx;
        int   guard;
        int   bad;
        logic acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        gray      = '0;

        check("model_3FF", model_dec(10'h3FF), 10'h2AA);
        check("model_200", model_dec(10'h200), 10'h3FF);
        check("model_003", model_dec(10'h003), 10'h002);
        check("model_007", model_dec(10'h007), 10'h005);
        check("model_hd", hamming(10'h001, 10'h007), 2);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            check($sformatf("rst_out_valid[%0d]", k), out_valid_w[k], 0);
            check($sformatf("rst_bin[%0d]", k), bin_w[k], 0);
            check($sformatf("rst_in_ready[%0d]", k), in_ready_w[k], 1);
            check($sformatf("rst_seq_err[%0d]", k), seq_err_w[k], 0);
            check($sformatf("rst_err_cnt[%0d]", k), err_cnt_w[k], 0);
        end

        got0.delete();
        send(10'h000);
        n = 0;
        for (int k = 0; k < ND; k++) lat[k] = 0;
        repeat (8) begin
            @(negedge clk);
            n++;
            for (int k = 0; k < ND; k++)
                if (out_valid_w[k] && lat[k] == 0) lat[k] = n;
        end
        for (int k = 0; k < ND; k++)
            check($sformatf("latency[%0d]", k), lat[k], ps(k));
        check("t1_count", got0.size(), 1);
        if (got0.size() >= 1) check("t1_word", got0[0], {1'b0, 10'h000});

        got0.delete();
        send(10'h3FF);
        send(10'h200);
        send(10'h003);
        drain();
        check("t2_count", got0.size(), 3);
        if (got0.size() >= 3) begin
            check("t2_3FF", got0[0], {CHK, 10'h2AA});
            check("t2_200", got0[1], {CHK, 10'h3FF});
            check("t2_003", got0[2], {CHK, 10'h002});
        end

        do_reset();
        got0.delete();
        idx   = 0;
        guard = 0;
        while (idx < 1024 && guard < 20000) begin
            gray      = W'(bin2gray(32'(idx)));
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready_w[0];
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        drain();
        check("t3_accepted", idx, 1024);
        check("t3_count", got0.size(), 1024);
        bad = -1;
        foreach (got0[i])
            if (bad < 0 && got0[i] !== {1'b0, W'(i)}) bad = i;
        check("t3_order", bad, -1);
        check("t3_err_cnt", err_cnt_w[0], 0);

        do_reset();
        got0.delete();
        send(10'h001);
        send(10'h007);
        send(10'h007);
        drain();
        check("t4_count", got0.size(), 3);
        if (got0.size() >= 3) begin
            check("t4_first", got0[0], {1'b0, 10'h001});
            check("t4_step2", got0[1], {CHK, 10'h005});
            check("t4_repeat", got0[2], {1'b0, 10'h005});
        end
        check("t4_err_cnt", err_cnt_w[0], 32'(CHK));

        do_reset();
        got0.delete();
        out_ready = 1'b0;
        send(10'h001);
        send(10'h007);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            check($sformatf("t5_out_valid[%0d]", k), out_valid_w[k], 0);
            check($sformatf("t5_err_cnt[%0d]", k), err_cnt_w[k], 0);
        end
        drain();
        check("t5_no_words", got0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
